// File: rtl/deadlock_report_ctrl.sv
// Confirms persistent deadlock-monitor block flags and reports each blocked monitor once, round-robin.
// Optional: define DEADLOCK_RPT_TIMESTAMP_EN to stamp each report with a free-running cycle count.
module deadlock_report_ctrl #(
    parameter int unsigned NUM_MON     = 4,
    parameter int unsigned INFO_W      = 9,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned IDX_W       = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [NUM_MON-1:0]        mon_block,
    input  logic [NUM_MON*INFO_W-1:0] mon_info,
    output logic                      rpt_valid,
    input  logic                      rpt_ready,
    output logic [IDX_W-1:0]          rpt_idx,
    output logic [INFO_W-1:0]         rpt_info,
    output logic [31:0]               rpt_cycles,
    output logic                      deadlock,
    output logic                      busy
);

    // 17 bits keeps the hold counter from wrapping for HOLD_CYCLES up to 2^16
    localparam int unsigned CNT_W = 17;
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);

    typedef enum logic [2:0] {IDLE, WATCH, CONFIRM, REPORT, HALT} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   cand_idx, cand_idx_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]   rpt_idx_d, scan_idx;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [NUM_MON-1:0] reported, reported_d;
    logic [INFO_W-1:0]  rpt_info_d;
    logic               rpt_valid_d, deadlock_d, busy_d, scan_hit;
    logic [SUM_W-1:0]   pos, rr_inc;
    logic [INFO_W-1:0]  info_arr [NUM_MON];

    always_comb begin
        for (int i = 0; i < NUM_MON; i++) begin
            info_arr[i] = mon_info[i*INFO_W +: INFO_W];
        end
    end

    // Circular search from rr_ptr; iterating downward lets the nearest hit win.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        pos      = '0;
        for (int k = NUM_MON - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + SUM_W'(k);
            if (pos >= SUM_W'(NUM_MON)) begin
                pos = pos - SUM_W'(NUM_MON);
            end
            if (mon_block[pos[IDX_W-1:0]] && !reported[pos[IDX_W-1:0]]) begin
                scan_hit = 1'b1;
                scan_idx = pos[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        rr_inc = {1'b0, rpt_idx} + SUM_W'(1);
        if (rr_inc >= SUM_W'(NUM_MON)) begin
            rr_inc = '0;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        cand_idx_d  = cand_idx;
        cnt_d       = cnt;
        reported_d  = reported;
        rr_ptr_d    = rr_ptr;
        rpt_valid_d = rpt_valid;
        rpt_idx_d   = rpt_idx;
        rpt_info_d  = rpt_info;
        deadlock_d  = deadlock;

        if (clear && state != HALT) begin
            reported_d = '0;
            deadlock_d = 1'b0;
        end

        case (state)
            IDLE: begin
                if (enable) state_d = WATCH;
            end
            WATCH: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (scan_hit) begin
                    cand_idx_d = scan_idx;
                    cnt_d      = CNT_W'(1);
                    state_d    = CONFIRM;
                end else if (reported_d != '0) begin
                    state_d = HALT;
                end
            end
            CONFIRM: begin
                if (!enable) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt >= HOLD_C) begin
                    rpt_valid_d = 1'b1;
                    rpt_idx_d   = cand_idx;
                    rpt_info_d  = info_arr[cand_idx];
                    state_d     = REPORT;
                end else if (!mon_block[cand_idx]) begin
                    cnt_d   = '0;
                    state_d = WATCH;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    rpt_valid_d         = 1'b0;
                    reported_d[rpt_idx] = 1'b1;
                    deadlock_d          = 1'b1;
                    rr_ptr_d            = rr_inc[IDX_W-1:0];
                    cnt_d               = '0;
                    state_d             = enable ? WATCH : IDLE;
                end
            end
            HALT: begin
                if (clear) begin
                    reported_d = '0;
                    deadlock_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CONFIRM) || (state_d == REPORT) || (state_d == HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cand_idx  <= '0;
            cnt       <= '0;
            reported  <= '0;
            rr_ptr    <= '0;
            rpt_valid <= 1'b0;
            rpt_idx   <= '0;
            rpt_info  <= '0;
            deadlock  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cand_idx  <= cand_idx_d;
            cnt       <= cnt_d;
            reported  <= reported_d;
            rr_ptr    <= rr_ptr_d;
            rpt_valid <= rpt_valid_d;
            rpt_idx   <= rpt_idx_d;
            rpt_info  <= rpt_info_d;
            deadlock  <= deadlock_d;
            busy      <= busy_d;
        end
    end

`ifdef DEADLOCK_RPT_TIMESTAMP_EN
    // Stamp taken on the cycle a report is confirmed (rising edge of rpt_valid)
    logic [31:0] cycle_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt  <= '0;
            rpt_cycles <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (rpt_valid_d && !rpt_valid) begin
                rpt_cycles <= cycle_cnt;
            end
        end
    end
`else
    assign rpt_cycles = '0;
`endif

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// Directed self-checking bench for deadlock_report_ctrl (NUM_MON=4, INFO_W=9, HOLD_CYCLES=16).
module tb_deadlock_report_ctrl;

    localparam int unsigned NUM_MON = 4;
    localparam int unsigned INFO_W  = 9;
    localparam int unsigned HOLD    = 16;
    localparam int unsigned IDX_W   = 2;

    localparam logic [8:0] INFO0 = 9'h033;
    localparam logic [8:0] INFO1 = 9'h15A;
    localparam logic [8:0] INFO2 = 9'h0C5;
    localparam logic [8:0] INFO3 = 9'h1A3;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      enable;
    logic                      clear;
    logic [NUM_MON-1:0]        mon_block;
    logic [NUM_MON*INFO_W-1:0] mon_info;
    logic                      rpt_valid;
    logic                      rpt_ready;
    logic [IDX_W-1:0]          rpt_idx;
    logic [INFO_W-1:0]         rpt_info;
    logic [31:0]               rpt_cycles;
    logic                      deadlock;
    logic                      busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    deadlock_report_ctrl #(
        .NUM_MON    (NUM_MON),
        .INFO_W     (INFO_W),
        .HOLD_CYCLES(HOLD),
        .IDX_W      (IDX_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .mon_block (mon_block),
        .mon_info  (mon_info),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_idx   (rpt_idx),
        .rpt_info  (rpt_info),
        .rpt_cycles(rpt_cycles),
        .deadlock  (deadlock),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        clear     = 1'b0;
        rpt_ready = 1'b0;
        mon_block = '0;
        mon_info  = {INFO3, INFO2, INFO1, INFO0};
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit seen, output int n_used);
        seen   = 1'b0;
        n_used = 0;
        for (int n = 1; n <= budget && !seen; n++) begin
            tick();
            n_used = n;
            if (rpt_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (rpt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rpt_valid); else pass_cnt++;
        total_cnt++; if (rpt_idx !== 2'd0) $display("FAIL reset_idx: got %0d want 0", rpt_idx); else pass_cnt++;
        total_cnt++; if (rpt_info !== 9'd0) $display("FAIL reset_info: got %h want 000", rpt_info); else pass_cnt++;
        total_cnt++; if (rpt_cycles !== 32'd0) $display("FAIL reset_cycles: got %0d want 0", rpt_cycles); else pass_cnt++;
        total_cnt++; if (deadlock !== 1'b0) $display("FAIL reset_deadlock: got %b want 0", deadlock); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_single_block();
        bit seen;
        int lat;
        do_reset();
        enable    = 1'b1;
        rpt_ready = 1'b1;
        tick();
        mon_block = 4'b0010;
        wait_valid(40, seen, lat);
        total_cnt++; if (!seen || lat != HOLD + 1) $display("FAIL single_latency: got %0d (seen %b) want %0d", lat, seen, HOLD + 1); else pass_cnt++;
        total_cnt++; if (rpt_idx !== 2'd1) $display("FAIL single_idx: got %0d want 1", rpt_idx); else pass_cnt++;
        total_cnt++; if (rpt_info !== INFO1) $display("FAIL single_info: got %h want %h", rpt_info, INFO1); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_report: got %b want 1", busy); else pass_cnt++;
        tick();
        total_cnt++; if (rpt_valid !== 1'b0) $display("FAIL single_valid_drop: got %b want 0", rpt_valid); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (deadlock !== 1'b1) $display("FAIL single_deadlock: got %b want 1", deadlock); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy_halt: got %b want 1", busy); else pass_cnt++;
        mon_block = '0;
    endtask

    task automatic test_transient();
        bit any_valid = 1'b0;
        do_reset();
        enable    = 1'b1;
        rpt_ready = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            mon_block = 4'b0001;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (rpt_valid !== 1'b0) any_valid = 1'b1;
            end
            mon_block = 4'b0000;
            for (int c = 0; c < 2; c++) begin
                tick();
                if (rpt_valid !== 1'b0) any_valid = 1'b1;
            end
        end
        total_cnt++; if (any_valid) $display("FAIL transient_valid: got 1 want 0"); else pass_cnt++;
        total_cnt++; if (deadlock !== 1'b0) $display("FAIL transient_deadlock: got %b want 0", deadlock); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL transient_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_idx [3];
        logic [8:0] exp_info [3];
        logic [1:0] got_idx [3];
        logic [8:0] got_info [3];
        int  got = 0;
        int  extra = 0;
        bit  seen;
        int  n_used;
        exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd3;
        exp_info[0] = INFO0; exp_info[1] = INFO1; exp_info[2] = INFO3;
        for (int i = 0; i < 3; i++) begin
            got_idx[i]  = 'x;
            got_info[i] = 'x;
        end
        do_reset();
        enable    = 1'b1;
        rpt_ready = 1'b1;
        mon_block = 4'b1011;
        for (int n = 0; n < 300 && got < 3; n++) begin
            tick();
            if (rpt_valid === 1'b1) begin
                got_idx[got]  = rpt_idx;
                got_info[got] = rpt_info;
                got++;
            end
        end
        for (int n = 0; n < 60; n++) begin
            tick();
            if (rpt_valid === 1'b1) extra++;
        end
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (got_idx[i] !== exp_idx[i]) $display("FAIL rr_idx%0d: got %0d want %0d", i, got_idx[i], exp_idx[i]); else pass_cnt++;
            total_cnt++; if (got_info[i] !== exp_info[i]) $display("FAIL rr_info%0d: got %h want %h", i, got_info[i], exp_info[i]); else pass_cnt++;
        end
        total_cnt++; if (got + extra != 3) $display("FAIL rr_count: got %0d want 3", got + extra); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL rr_halt_busy: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (deadlock !== 1'b1) $display("FAIL rr_deadlock: got %b want 1", deadlock); else pass_cnt++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total_cnt++; if (deadlock !== 1'b0) $display("FAIL rr_clear_deadlock: got %b want 0", deadlock); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rr_clear_idle: got %b want 0", busy); else pass_cnt++;
        wait_valid(60, seen, n_used);
        total_cnt++; if (!seen || rpt_idx !== 2'd0) $display("FAIL rr_rescan_idx: got %0d (seen %b) want 0", rpt_idx, seen); else pass_cnt++;
        tick();
        mon_block = '0;
    endtask

    task automatic test_back_pressure();
        bit seen;
        int n_used;
        bit unstable = 1'b0;
        int after = 0;
        do_reset();
        enable    = 1'b1;
        rpt_ready = 1'b0;
        mon_block = 4'b0100;
        wait_valid(40, seen, n_used);
        total_cnt++; if (!seen) $display("FAIL bp_valid: got 0 want 1"); else pass_cnt++;
        for (int c = 0; c < 50; c++) begin
            mon_info = {$urandom, $urandom}[35:0];
            tick();
            if (rpt_valid !== 1'b1 || rpt_idx !== 2'd2 || rpt_info !== INFO2) unstable = 1'b1;
        end
        total_cnt++; if (unstable) $display("FAIL bp_stable: got idx %0d info %h valid %b want 2 %h 1", rpt_idx, rpt_info, rpt_valid, INFO2); else pass_cnt++;
        total_cnt++; if (rpt_idx !== 2'd2) $display("FAIL bp_idx: got %0d want 2", rpt_idx); else pass_cnt++;
        total_cnt++; if (rpt_info !== INFO2) $display("FAIL bp_info: got %h want %h", rpt_info, INFO2); else pass_cnt++;
        rpt_ready = 1'b1;
        tick();
        total_cnt++; if (rpt_valid !== 1'b0) $display("FAIL bp_accept_drop: got %b want 0", rpt_valid); else pass_cnt++;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (rpt_valid === 1'b1) after++;
        end
        total_cnt++; if (after != 0) $display("FAIL bp_single_transfer: got %0d extra want 0", after); else pass_cnt++;
        mon_block = '0;
        mon_info  = {INFO3, INFO2, INFO1, INFO0};
    endtask

    task automatic test_reset_mid_report();
        bit seen;
        int n_used;
        do_reset();
        enable    = 1'b1;
        rpt_ready = 1'b1;
        mon_block = 4'b0011;
        wait_valid(40, seen, n_used);
        tick();
        rpt_ready = 1'b0;
        wait_valid(40, seen, n_used);
        total_cnt++; if (!seen || rpt_idx !== 2'd1) $display("FAIL rst_mid_pending: got idx %0d (seen %b) want 1", rpt_idx, seen); else pass_cnt++;
        total_cnt++; if (deadlock !== 1'b1) $display("FAIL rst_mid_pre_deadlock: got %b want 1", deadlock); else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++; if (rpt_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", rpt_valid); else pass_cnt++;
        total_cnt++; if (deadlock !== 1'b0) $display("FAIL rst_mid_deadlock: got %b want 0", deadlock); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else pass_cnt++;
        reset     = 1'b0;
        mon_block = 4'b0001;
        rpt_ready = 1'b1;
        wait_valid(40, seen, n_used);
        total_cnt++; if (!seen || rpt_idx !== 2'd0) $display("FAIL rst_mid_rereport: got idx %0d (seen %b) want 0", rpt_idx, seen); else pass_cnt++;
        tick();
        mon_block = '0;
    endtask

    task automatic test_timestamp();
        bit seen;
        int n_used;
        logic [31:0] exp_cycles;
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
        exp_cycles = 32'd116;
`else
        exp_cycles = 32'd0;
`endif
        do_reset();
        enable    = 1'b1;
        rpt_ready = 1'b0;
        for (int c = 0; c < 100; c++) tick();
        mon_block = 4'b1000;
        wait_valid(40, seen, n_used);
        total_cnt++; if (!seen || rpt_cycles !== exp_cycles) $display("FAIL timestamp: got %0d (seen %b) want %0d", rpt_cycles, seen, exp_cycles); else pass_cnt++;
        rpt_ready = 1'b1;
        tick();
        mon_block = '0;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_transient();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_report();
        test_timestamp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
